mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the request address width in bits.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width in bits.
REQ-003 Parameter DEPTH, default 1024, SHALL set the number of implemented words; legal range is 1..2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait states per access; legal range is 0..15.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 req_valid  input  1  SHALL indicate that the initiator presents a request.
REQ-008 req_ready  output  1  SHALL indicate that the responder accepts a request this cycle.
REQ-009 req_write  input  1  SHALL select write (1) or read (0).
REQ-010 req_adr  input  ADDR_W  SHALL carry the word address.
REQ-011 req_data  input  DATA_W  SHALL carry the write data.
REQ-012 resp_valid  output  1  SHALL indicate that a response is presented.
REQ-013 resp_ready  input  1  SHALL indicate that the initiator consumes the response.
REQ-014 resp_data  output  DATA_W  SHALL carry the read data, or 0 for writes and errors.
REQ-015 resp_err  output  1  SHALL flag an out-of-range address (req_adr >= DEPTH).

Function
REQ-016 The block SHALL use an FSM with states IDLE, WAIT and RESP.
REQ-017 IDLE: req_ready=1, resp_valid=0; accept when req_valid and req_ready are both high at an edge; capture req_write, req_adr and req_data; load the wait counter with WAIT_CYCLES.
REQ-018 On accept, the FSM SHALL go to WAIT if WAIT_CYCLES>0, else commit the access at the same edge and go to RESP.
REQ-019 WAIT: req_ready=0; the counter SHALL decrement each cycle; at the edge where the counter equals 1, the access SHALL commit and the FSM SHALL go to RESP.
REQ-020 Latency: for an accept in cycle c, resp_valid SHALL first be high in cycle c+1+WAIT_CYCLES.
REQ-021 Commit of an in-range write SHALL update the array at the commit edge; resp_data=0, resp_err=0.
REQ-022 Commit of an in-range read SHALL register the array word into resp_data; resp_err=0.
REQ-023 Commit of an out-of-range access SHALL perform no array write; resp_data=0, resp_err=1.
REQ-024 RESP: resp_valid=1, req_ready=0; resp_data and resp_err SHALL hold stable until resp_ready is high at an edge, then the FSM SHALL return to IDLE.
REQ-025 No request SHALL be accepted in the cycle the response is consumed; back-to-back throughput is one access per WAIT_CYCLES+2 cycles, minimum.
REQ-026 req_valid while in WAIT or RESP SHALL be ignored; the captured request SHALL be unaffected by input changes after accept.
REQ-027 A read following a committed write to the same address SHALL return the new data.
REQ-028 Array addressing SHALL use req_adr directly, with no wrap-around; addresses >= DEPTH are errors per REQ-023.

Reset
REQ-029 rst high at an edge SHALL force IDLE; req_ready=1, resp_valid=0, resp_data=0, resp_err=0, counter=0.
REQ-030 rst during WAIT SHALL abort the access; a pending write SHALL NOT modify the array.
REQ-031 rst SHALL NOT clear array contents; contents are undefined until written.
REQ-032 rst SHALL have priority over every simultaneous handshake.

Structure
REQ-033 Package mem_pkg SHALL hold the FSM state type, the default ADDR_W and DATA_W, and the WAIT_CYCLES width constant (4).
REQ-034 Sub-module mem_array SHALL implement the DEPTH x DATA_W storage: synchronous write, combinational read, instantiated once.

Verification
REQ-035 WAIT_CYCLES=2: write 0x1234 to 0x005, then read 0x005 -> resp_valid high in cycle c+3 for each access; read resp_data=0x1234, resp_err=0.
REQ-036 WAIT_CYCLES=0: accept in cycle c -> resp_valid in cycle c+1; hold resp_ready=0 for 4 cycles -> resp_valid and resp_data stay stable, req_ready=0.
REQ-037 DEPTH=512: read 0x200 -> resp_err=1, resp_data=0; write 0xBEEF to 0x200, then read 0x000 -> prior contents unchanged.
REQ-038 Write 0xAAAA to 0x010 and commit; write 0x5555 to 0x010 with rst asserted in WAIT -> FSM in IDLE; read 0x010 returns 0xAAAA.
REQ-039 Toggle req_valid, req_adr and req_data during WAIT and RESP -> no second accept; response matches the first captured request.
REQ-040 Back-to-back reads with resp_ready tied high, WAIT_CYCLES=2 -> accepts spaced exactly 4 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the FSM state type and the default widths used by mem_responder.
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word storage: synchronous write port, combinational read port.
// Callers guarantee addresses are in range; contents are never reset.
module mem_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_adr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_adr,
  output logic [DATA_W-1:0] o_rd_data_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_wr_idx = IDX_W'(i_wr_adr);
  assign w_rd_idx = IDX_W'(i_rd_adr);

  // write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data_c = r_mem[w_rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed number of wait states.
// Requests are captured on accept and committed after WAIT_CYCLES cycles.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              r_write;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_data;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic              w_capture;
  logic              w_commit;
  logic              w_cmt_write;
  logic [ADDR_W-1:0] w_cmt_adr;
  logic [DATA_W-1:0] w_cmt_data;
  logic              w_cmt_err;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_rd_data;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state, wait counter and commit decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_capture = 1'b1;
          w_cnt_nxt = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            w_commit    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A zero-wait commit happens on the accept edge, so it must use the live request.
  always_comb begin
    w_cmt_write = r_write;
    w_cmt_adr   = r_adr;
    w_cmt_data  = r_data;
    if (r_state == S_IDLE) begin
      w_cmt_write = req_write;
      w_cmt_adr   = req_adr;
      w_cmt_data  = req_data;
    end
  end

  assign w_cmt_err = (32'(w_cmt_adr) >= DEPTH);
  assign w_mem_we  = w_commit & w_cmt_write & ~w_cmt_err & ~rst;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk         (clk),
    .i_we        (w_mem_we),
    .i_wr_adr    (w_cmt_adr),
    .i_wr_data   (w_cmt_data),
    .i_rd_adr    (w_cmt_adr),
    .o_rd_data_c (w_rd_data)
  );

  // counter, captured request and registered handshake/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_adr        <= '0;
      r_data       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      if (w_capture) begin
        r_write <= req_write;
        r_adr   <= req_adr;
        r_data  <= req_data;
      end
      if (w_commit) begin
        r_resp_err  <= w_cmt_err;
        r_resp_data <= (w_cmt_write || w_cmt_err) ? '0 : w_rd_data;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (2 waits / 0 waits / DEPTH=512)
// checked against a word-array model with randomized and directed accesses.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;

  logic        req_valid  [3];
  logic        req_write  [3];
  logic [9:0]  req_adr    [3];
  logic [15:0] req_data   [3];
  logic        resp_ready [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [15:0] resp_data  [3];
  logic        resp_err   [3];

  logic [15:0] m_mem   [3][1024];
  bit          m_known [3][1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_adr(req_adr[0]), .req_data(req_data[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0]));

  mem_responder #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_adr(req_adr[1]), .req_data(req_data[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1]));

  mem_responder #(.DEPTH(512), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_adr(req_adr[2]), .req_data(req_data[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_data(resp_data[2]), .resp_err(resp_err[2]));

  function automatic int wait_of(input int k);
    return (k == 1) ? 0 : 2;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 2) ? 512 : 1024;
  endfunction

  task automatic scramble(input int k);
    req_valid[k] = 1'($urandom);
    req_write[k] = 1'($urandom);
    req_adr[k]   = 10'($urandom);
    req_data[k]  = 16'($urandom);
  endtask

  // one full request/response transaction on instance k, checked against the model
  task automatic do_access(input int k, input bit wr, input logic [9:0] adr,
                           input logic [15:0] data, input int hold, input bit toggle);
    int n;
    bit got, ready_bad, stable, chk_d, exp_e;
    logic [15:0] exp_d, d0;
    logic e0;
    exp_e = (int'(adr) >= depth_of(k));
    exp_d = '0;
    chk_d = 1'b1;
    if (!exp_e && !wr) begin
      if (m_known[k][adr]) exp_d = m_mem[k][adr];
      else chk_d = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (req_ready[k] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready dut%0d: req_ready=%b expected 1", k, req_ready[k]);
    end
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_adr[k]   = adr;
    req_data[k]  = data;
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    if (wr && !exp_e) begin
      m_mem[k][adr]   = data;
      m_known[k][adr] = 1'b1;
    end
    got = 1'b0;
    ready_bad = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (toggle) scramble(k);
      if (resp_valid[k] === 1'b1) got = 1'b1;
      else if (req_ready[k] !== 1'b0) ready_bad = 1'b1;
    end
    n_tests++;
    if (!got || n != wait_of(k) + 1) begin
      n_fail++;
      $display("FAIL latency dut%0d adr=%h: resp_valid after %0d cycles (seen=%b) expected %0d",
               k, adr, n, got, wait_of(k) + 1);
      if (!got) begin
        req_valid[k] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    n_tests++;
    if (ready_bad || req_ready[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready dut%0d: req_ready high while busy, expected 0", k);
    end
    n_tests++;
    if (resp_err[k] !== exp_e) begin
      n_fail++;
      $display("FAIL resp_err dut%0d adr=%h: got %b expected %b", k, adr, resp_err[k], exp_e);
    end
    if (chk_d) begin
      n_tests++;
      if (resp_data[k] !== exp_d) begin
        n_fail++;
        $display("FAIL resp_data dut%0d adr=%h wr=%b: got %h expected %h",
                 k, adr, wr, resp_data[k], exp_d);
      end
    end
    d0 = resp_data[k];
    e0 = resp_err[k];
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (toggle) scramble(k);
      if (resp_valid[k] !== 1'b1 || resp_data[k] !== d0 || resp_err[k] !== e0 ||
          req_ready[k] !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) begin
      n_tests++;
      if (!stable) begin
        n_fail++;
        $display("FAIL resp_hold dut%0d: response changed while stalled, expected data %h err %b held",
                 k, d0, e0);
      end
    end
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b0;
    @(posedge clk);
    #1;
    resp_ready[k] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0) begin
      n_fail++;
      $display("FAIL return_idle dut%0d: req_ready=%b resp_valid=%b expected 1/0",
               k, req_ready[k], resp_valid[k]);
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 ||
          resp_data[k] !== 16'h0 || resp_err[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: rdy=%b vld=%b data=%h err=%b expected 1/0/0000/0",
                 k, req_ready[k], resp_valid[k], resp_data[k], resp_err[k]);
      end
    end
    // reset while a response is presented, concurrent with resp_ready
    do_access(0, 1'b1, 10'h3C0, 16'h7E7E, 0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_adr[0] = 10'h3C0;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 ||
        resp_data[0] !== 16'h0 || resp_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_resp: rdy=%b vld=%b data=%h err=%b expected 1/0/0000/0",
               req_ready[0], resp_valid[0], resp_data[0], resp_err[0]);
    end
  endtask

  task automatic test_basic;
    do_access(0, 1'b1, 10'h005, 16'h1234, 0, 1'b0);
    do_access(0, 1'b0, 10'h005, 16'h0000, 0, 1'b0);
    do_access(2, 1'b1, 10'h005, 16'hCAFE, 1, 1'b0);
    do_access(2, 1'b0, 10'h005, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_zero_wait_hold;
    do_access(1, 1'b1, 10'h007, 16'h00C3, 4, 1'b0);
    do_access(1, 1'b0, 10'h007, 16'h0000, 4, 1'b0);
    do_access(1, 1'b0, 10'h3FF, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_depth_boundary;
    do_access(2, 1'b1, 10'h000, 16'h1357, 0, 1'b0);
    do_access(2, 1'b0, 10'h200, 16'h0000, 0, 1'b0);
    do_access(2, 1'b1, 10'h200, 16'hBEEF, 0, 1'b0);
    do_access(2, 1'b0, 10'h000, 16'h0000, 0, 1'b0);
    do_access(2, 1'b1, 10'h1FF, 16'h2468, 0, 1'b0);
    do_access(2, 1'b0, 10'h1FF, 16'h0000, 2, 1'b0);
    do_access(2, 1'b0, 10'h3FF, 16'h0000, 0, 1'b0);
  endtask

  // reset lands either in the first wait cycle or on the would-be commit edge
  task automatic test_reset_abort;
    do_access(0, 1'b1, 10'h010, 16'hAAAA, 0, 1'b0);
    for (int abort_n = 1; abort_n <= 2; abort_n++) begin
      @(negedge clk);
      req_valid[0] = 1'b1; req_write[0] = 1'b1;
      req_adr[0] = 10'h010; req_data[0] = 16'h5555;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      repeat (abort_n) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 ||
          resp_data[0] !== 16'h0 || resp_err[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_state n=%0d: rdy=%b vld=%b data=%h err=%b expected 1/0/0000/0",
                 abort_n, req_ready[0], resp_valid[0], resp_data[0], resp_err[0]);
      end
      do_access(0, 1'b0, 10'h010, 16'h0000, 0, 1'b0);
    end
  endtask

  task automatic test_toggle;
    do_access(0, 1'b1, 10'h021, 16'h0F1E, 0, 1'b0);
    do_access(0, 1'b0, 10'h021, 16'h0000, 3, 1'b1);
    do_access(0, 1'b1, 10'h022, 16'h9876, 3, 1'b1);
    do_access(1, 1'b1, 10'h023, 16'h4321, 3, 1'b1);
    do_access(1, 1'b0, 10'h023, 16'h0000, 2, 1'b1);
    do_access(0, 1'b0, 10'h022, 16'h0000, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [9:0] adr;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: adr = 10'h000;
        1: adr = 10'h3FF;
        2: adr = 10'h1FF;
        3: adr = 10'h200;
        default: adr = 10'($urandom_range(0, 15));
      endcase
      do_access(i % 3, 1'($urandom), adr, 16'($urandom),
                int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    bit data_ok;
    bit drained;
    do_access(0, 1'b1, 10'h0C3, 16'h0F0F, 0, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_adr[0] = 10'h0C3;
    resp_ready[0] = 1'b1;
    data_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready[0] === 1'b1) acc.push_back(c);
      if (resp_valid[0] === 1'b1 && (resp_data[0] !== 16'h0F0F || resp_err[0] !== 1'b0))
        data_ok = 1'b0;
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      @(negedge clk);
      if (req_ready[0] === 1'b1 && resp_valid[0] === 1'b0) drained = 1'b1;
    end
    resp_ready[0] = 1'b0;
    n_tests++;
    if (!drained) begin
      n_fail++;
      $display("FAIL b2b_drain: responder did not return to idle, expected idle");
    end
    n_tests++;
    if (!data_ok) begin
      n_fail++;
      $display("FAIL b2b_data: a streamed read returned wrong data, expected 0f0f err 0");
    end
    n_tests++;
    if (acc.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: %0d accepts in 30 cycles expected 8", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_tests++;
      if (acc[i] - acc[i-1] != 4) begin
        n_fail++;
        $display("FAIL b2b_spacing: accept gap %0d expected 4", acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_adr[k] = '0;
      req_data[k] = '0; resp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_zero_wait_hold;
    test_depth_boundary;
    test_reset_abort;
    test_toggle;
    test_random;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
